cc_unit: RTL and testbench

CC_UNIT -- requirements
Module: cc_unit

---
 rtl/cc_unit.sv | 92 +++++++++
 tb/tb_cc_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_unit.sv
// Condition-code unit: classifies a bus value into one-hot {N,Z,P}, keeps a
// LIFO save stack of condition codes for interrupt entry/return, and registers branch decisions.
module cc_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus,
    input  logic             cc_ld,
    input  logic             cc_save,
    input  logic             cc_restore,
    input  logic             br_en,
    input  logic [2:0]       br_mask,
    input  logic             err_clr,
    output logic [2:0]       nzp,
    output logic             br_taken,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] count;
    logic [2:0]    stk [DEPTH];
    logic [2:0]    cls;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          conflict;
    logic          push_ok;
    logic          pop_ok;
    logic          err_ev;

    always_comb begin
        cls = 3'b001;
        if (bus == '0)
            cls = 3'b010;
        else if (bus[WIDTH-1])
            cls = 3'b100;
    end

    assign stk_full  = (count == CW'(DEPTH));
    assign stk_empty = (count == '0);

    // Indices are only used when the matching push/pop is legal, so the
    // truncation never selects a non-existent entry.
    assign wr_idx = IW'(count);
    assign rd_idx = IW'(count - CW'(1));

    assign conflict = cc_save & cc_restore;
    assign push_ok  = cc_save & ~cc_restore & ~stk_full;
    assign pop_ok   = cc_restore & ~cc_save & ~stk_empty;
    assign err_ev   = conflict
                    | (cc_save & ~cc_restore & stk_full)
                    | (cc_restore & ~cc_save & stk_empty);

    // Stack storage is not reset; only the count defines valid entries.
    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            stk[wr_idx] <= nzp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nzp      <= 3'b010;
            br_taken <= 1'b0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            br_taken <= br_en & |(br_mask & nzp);

            // A legal restore wins over cc_ld; a save/restore conflict freezes nzp.
            if (pop_ok)
                nzp <= stk[rd_idx];
            else if (!conflict && cc_ld)
                nzp <= cls;

            if (pop_ok)
                count <= count - CW'(1);
            else if (push_ok)
                count <= count + CW'(1);

            if (err_ev)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cc_unit.sv
// Self-checking bench for cc_unit: vector table, hand-written stack/branch
// sequences, and randomized traffic scored against a queue-based model.
module tb_cc_unit;

    parameter int WIDTH = 16;
    parameter int DEPTH = 4;

    localparam logic [WIDTH-1:0] B_ZERO = '0;
    localparam logic [WIDTH-1:0] B_MSB  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] B_POS  = ~B_MSB;
    localparam logic [WIDTH-1:0] B_ONES = '1;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] bus;
    logic             cc_ld;
    logic             cc_save;
    logic             cc_restore;
    logic             br_en;
    logic [2:0]       br_mask;
    logic             err_clr;
    logic [2:0]       nzp;
    logic             br_taken;
    logic             stk_full;
    logic             stk_empty;
    logic             err;

    cc_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus), .cc_ld(cc_ld), .cc_save(cc_save),
        .cc_restore(cc_restore), .br_en(br_en), .br_mask(br_mask),
        .err_clr(err_clr), .nzp(nzp), .br_taken(br_taken),
        .stk_full(stk_full), .stk_empty(stk_empty), .err(err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [2:0] m_nzp;
    logic       m_br;
    logic       m_err;
    logic [2:0] m_stack[$];

    function automatic logic [2:0] classify(input logic [WIDTH-1:0] b);
        if (b == 0) return 3'b010;
        if ($signed(b) < 0) return 3'b100;
        return 3'b001;
    endfunction

    task automatic model_step(input logic r, ld, sv, rs, be, ec,
                              input logic [WIDTH-1:0] b, input logic [2:0] mk);
        logic [2:0] next_nzp;
        logic       bad;
        if (r) begin
            m_nzp = 3'b010;
            m_br  = 1'b0;
            m_err = 1'b0;
            m_stack.delete();
            return;
        end
        m_br     = be && ((mk & m_nzp) != 3'b000);
        next_nzp = m_nzp;
        bad      = 1'b0;
        if (sv && rs) begin
            bad = 1'b1;
        end else if (rs) begin
            if (m_stack.size() == 0) begin
                bad = 1'b1;
                if (ld) next_nzp = classify(b);
            end else begin
                next_nzp = m_stack.pop_back();
            end
        end else begin
            if (sv) begin
                if (m_stack.size() == DEPTH) bad = 1'b1;
                else m_stack.push_back(m_nzp);
            end
            if (ld) next_nzp = classify(b);
        end
        m_nzp = next_nzp;
        if (bad) m_err = 1'b1;
        else if (ec) m_err = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_pass  = 0;
    logic [6:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic r, ld, sv, rs, be, ec,
                         input logic [WIDTH-1:0] b, input logic [2:0] mk);
        logic [6:0] e;
        rst = r; cc_ld = ld; cc_save = sv; cc_restore = rs;
        br_en = be; err_clr = ec; bus = b; br_mask = mk;
        model_step(r, ld, sv, rs, be, ec, b, mk);
        exp_q.push_back({m_nzp, m_br, (m_stack.size() == DEPTH),
                         (m_stack.size() == 0), m_err});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("sb_outputs", {nzp, br_taken, stk_full, stk_empty, err}, e);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, B_ZERO, 3'b000);
    endtask

    task automatic load(input logic [WIDTH-1:0] b);
        cycle(0, 1, 0, 0, 0, 0, b, 3'b000);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0, B_ZERO, 3'b000);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             ld;
        logic [WIDTH-1:0] b;
        logic             be;
        logic [2:0]       mk;
        logic [2:0]       e_nzp;
        logic             e_br;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic ld, input logic [WIDTH-1:0] b, input logic be,
                           input logic [2:0] mk, input logic [2:0] e_nzp, input logic e_br);
        vec_t v;
        v.ld = ld; v.b = b; v.be = be; v.mk = mk; v.e_nzp = e_nzp; v.e_br = e_br;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; bus = '0; cc_ld = 0; cc_save = 0; cc_restore = 0;
        br_en = 0; br_mask = 0; err_clr = 0;
        m_nzp = 3'b010; m_br = 0; m_err = 0;

        add_vec(1, B_ZERO, 0, 3'b000, 3'b010, 0);
        add_vec(1, B_MSB,  0, 3'b000, 3'b100, 0);
        add_vec(1, B_POS,  0, 3'b000, 3'b001, 0);
        add_vec(1, B_ONES, 0, 3'b000, 3'b100, 0);
        add_vec(1, B_POS,  0, 3'b000, 3'b001, 0);
        add_vec(0, B_ZERO, 1, 3'b010, 3'b001, 0);
        add_vec(0, B_ZERO, 1, 3'b011, 3'b001, 1);
        add_vec(1, B_ZERO, 1, 3'b111, 3'b010, 1);
        add_vec(0, B_ZERO, 1, 3'b000, 3'b010, 0);
        add_vec(0, B_ZERO, 0, 3'b111, 3'b010, 0);
        add_vec(1, B_MSB,  1, 3'b111, 3'b100, 1);
        add_vec(0, B_ZERO, 0, 3'b111, 3'b100, 0);

        // Reset, including reset held with other inputs active.
        do_reset();
        cycle(1, 1, 1, 0, 1, 0, B_MSB, 3'b111);
        chk("rst_nzp", nzp, 3'b010);
        chk("rst_br", br_taken, 1'b0);
        chk("rst_empty", stk_empty, 1'b1);
        chk("rst_full", stk_full, 1'b0);
        chk("rst_err", err, 1'b0);

        foreach (vecs[i]) begin
            cycle(0, vecs[i].ld, 0, 0, vecs[i].be, 0, vecs[i].b, vecs[i].mk);
            chk($sformatf("vec%0d_nzp", i), nzp, vecs[i].e_nzp);
            chk($sformatf("vec%0d_br", i), br_taken, vecs[i].e_br);
        end

        // Nested save/restore.
        do_reset();
        load(B_MSB);
        cycle(0, 0, 1, 0, 0, 0, B_ZERO, 3'b000);
        load(B_POS);
        cycle(0, 0, 1, 0, 0, 0, B_ZERO, 3'b000);
        load(B_ZERO);
        chk("nest_z", nzp, 3'b010);
        cycle(0, 1, 0, 1, 0, 0, B_MSB, 3'b000);
        chk("nest_pop1", nzp, (DEPTH >= 2) ? 3'b001 : 3'b100);
        cycle(0, 0, 0, 1, 0, 0, B_ZERO, 3'b000);
        chk("nest_pop2", nzp, 3'b100);
        chk("nest_empty", stk_empty, 1'b1);
        chk("nest_err", err, (DEPTH >= 2) ? 1'b0 : 1'b1);

        // Overflow: DEPTH+1 pushes.
        do_reset();
        for (int i = 1; i <= DEPTH + 1; i++) begin
            cycle(0, 0, 1, 0, 0, 0, B_ZERO, 3'b000);
            chk($sformatf("ovf_full%0d", i), stk_full, (i >= DEPTH));
            chk($sformatf("ovf_err%0d", i), err, (i > DEPTH));
        end
        // Overflow together with err_clr: error wins; concurrent load still applies.
        cycle(0, 1, 1, 0, 0, 1, B_POS, 3'b000);
        chk("ovf_clr_err", err, 1'b1);
        chk("ovf_ld_nzp", nzp, 3'b001);

        // Underflow after reset.
        do_reset();
        cycle(0, 0, 0, 1, 0, 0, B_ZERO, 3'b000);
        chk("unf_err", err, 1'b1);
        chk("unf_nzp", nzp, 3'b010);
        chk("unf_empty", stk_empty, 1'b1);
        cycle(0, 0, 0, 0, 0, 1, B_ZERO, 3'b000);
        chk("unf_clr", err, 1'b0);

        // Conflict: save+restore+load freezes nzp and count.
        do_reset();
        load(B_POS);
        cycle(0, 0, 1, 0, 0, 0, B_ZERO, 3'b000);
        cycle(0, 0, 1, 0, 0, 0, B_ZERO, 3'b000);
        cycle(0, 0, 0, 0, 0, 1, B_ZERO, 3'b000);
        cycle(0, 1, 1, 1, 0, 0, B_MSB, 3'b000);
        chk("cfl_nzp", nzp, 3'b001);
        chk("cfl_err", err, 1'b1);
        chk("cfl_empty", stk_empty, 1'b0);
        cycle(0, 0, 0, 0, 0, 1, B_ZERO, 3'b000);
        chk("cfl_clr", err, 1'b0);

        // Reset mid-sequence discards entries.
        cycle(0, 0, 1, 0, 0, 0, B_ZERO, 3'b000);
        do_reset();
        chk("mid_rst_empty", stk_empty, 1'b1);
        idle();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [WIDTH-1:0] b;
            case ($urandom_range(0, 3))
                0: b = B_ZERO;
                1: b = B_MSB;
                2: b = B_ONES;
                default: b = WIDTH'({$urandom(), $urandom()});
            endcase
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 7) == 0),
                  b, 3'($urandom_range(0, 7)));
            chk("rand_onehot", $onehot(nzp), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
